reminder_scheduler: RTL
=======================

REMINDER_SCHEDULER -- requirements
Module: reminder_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per one-second tick (legal range 2 or greater).
REQ-002 Parameter SNOOZE_MIN, default 2, snooze length in whole minutes (legal range 1..9).
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level, sampled each cycle; arms the reminder from IDLE.
REQ-006 stop  input  1  level; returns to IDLE from any state.
REQ-007 ack  input  1  user confirms drink.
REQ-008 snooze  input  1  user defers alert.
REQ-009 int_min1, int_min0  input  4 each  BCD reminder interval, minutes tens/ones.
REQ-010 sec1, sec0, min1, min0  output  4 each  BCD elapsed time mm:ss since last (re)arm.
REQ-011 alert  output  1  high while in ALERT.
REQ-012 state  output  2  IDLE=0, COUNTING=1, ALERT=2, SNOOZE=3.
REQ-013 missed  output  4  count of unanswered alerts, saturating.

Function
REQ-014 All outputs SHALL be registered; inputs SHALL take effect on the next posedge.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 in COUNTING, ALERT and SNOOZE; tick = prescaler at TICK_DIV-1; prescaler SHALL then wrap to 0.
REQ-016 On tick in COUNTING/SNOOZE, time SHALL advance BCD: sec0 9->0 carries into sec1; sec1:sec0 59->00 carries into minutes; min 99:59 wraps to 00:00.
REQ-017 IDLE: time 00:00, prescaler 0, alert 0; start=1 with valid interval SHALL latch int_min1/int_min0 and enter COUNTING.
REQ-018 Valid interval: both digits 0..9 and not 00; otherwise start SHALL be ignored (remain IDLE).
REQ-019 COUNTING: on the tick making time equal latched_interval:00, SHALL enter ALERT in the same edge; alert=1 from that cycle.
REQ-020 ALERT: time held; prescaler keeps running and counts alert seconds 0..59.
REQ-021 ALERT, ack=1: SHALL enter COUNTING with time 00:00, prescaler 0, alert-second count 0.
REQ-022 ALERT, snooze=1 (ack=0): SHALL enter SNOOZE with time 00:00, prescaler 0.
REQ-023 ALERT, 60th alert-second tick with no ack/snooze: missed SHALL increment (saturate at 15) and SHALL enter COUNTING with time 00:00.
REQ-024 SNOOZE: on tick reaching SNOOZE_MIN:00, SHALL enter ALERT; ack=1 SHALL enter COUNTING with time 00:00; snooze=1 ignored.
REQ-025 Priority per cycle: reset > stop > ack > snooze > tick-driven transitions.
REQ-026 stop SHALL enter IDLE, clear time and prescaler, clear alert; missed SHALL be retained.
REQ-027 start while not IDLE SHALL be ignored; changes to int_min* after arming SHALL have no effect until next arm.
REQ-028 ack/snooze in IDLE or COUNTING SHALL be ignored.

Reset
REQ-029 reset=1 SHALL force state IDLE, time 00:00, prescaler 0, alert 0, missed 0, latched interval 00, in the cycle after assertion, regardless of state.
REQ-030 Reset mid-ALERT or mid-SNOOZE SHALL discard pending transitions; no missed increment.

Verification (TICK_DIV=4, SNOOZE_MIN=2)
REQ-031 Interval 01, start -> state=1; after 60x4 cycles time 01:00, state=2, alert=1 same edge.
REQ-032 In ALERT, ack and snooze asserted same cycle -> state=1, time 00:00, missed unchanged.
REQ-033 Snooze in ALERT -> state=3; after 120x4 cycles alert=1 again.
REQ-034 ALERT left 60 ticks unanswered -> missed +1, state=1; 16 repetitions -> missed stays 15.
REQ-035 int_min=00 or int_min0=4'hA with start -> state stays 0; BCD sec 09->10, 59->00 with minute carry checked.
REQ-036 Reset asserted in SNOOZE at time 01:30 -> next cycle all outputs zero, state=0.

Source files
------------

// File: rtl/reminder_scheduler.sv
// rtl/reminder_scheduler.sv - drink reminder timer with BCD mm:ss, alert, snooze and missed count
module reminder_scheduler #(
  parameter int TICK_DIV   = 50000000,
  parameter int SNOOZE_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  input  logic       snooze,
  input  logic [3:0] int_min1,
  input  logic [3:0] int_min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic       alert,
  output logic [1:0] state,
  output logic [3:0] missed
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] SNOOZE_DIGIT = 4'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_ALERT    = 2'd2,
    S_SNOOZE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    sec1_q, sec0_q, min1_q, min0_q;
  logic [3:0]    sec1_d, sec0_d, min1_d, min0_d;
  logic [5:0]    asec_q;
  logic [3:0]    missed_q;
  logic          alert_q;
  logic [3:0]    ilat1_q, ilat0_q;

  logic          tick;
  logic          hit_interval;
  logic          hit_snooze;
  logic          start_ok;
  logic [PW-1:0] presc_next;

  assign tick         = (presc_q == PRESC_MAX);
  assign presc_next   = tick ? '0 : presc_q + PW'(1);
  assign hit_interval = ({min1_d, min0_d, sec1_d, sec0_d} == {ilat1_q, ilat0_q, 8'h00});
  assign hit_snooze   = ({min1_d, min0_d, sec1_d, sec0_d} == {4'd0, SNOOZE_DIGIT, 8'h00});
  assign start_ok     = start && (int_min1 <= 4'd9) && (int_min0 <= 4'd9) &&
                        ({int_min1, int_min0} != 8'h00);

  // BCD mm:ss one second ahead of the current time, wrapping 99:59 to 00:00
  always_comb begin
    sec1_d = sec1_q;
    sec0_d = sec0_q;
    min1_d = min1_q;
    min0_d = min0_q;
    if (sec0_q == 4'd9) begin
      sec0_d = 4'd0;
      if (sec1_q == 4'd5) begin
        sec1_d = 4'd0;
        if (min0_q == 4'd9) begin
          min0_d = 4'd0;
          min1_d = (min1_q == 4'd9) ? 4'd0 : min1_q + 4'd1;
        end else begin
          min0_d = min0_q + 4'd1;
        end
      end else begin
        sec1_d = sec1_q + 4'd1;
      end
    end else begin
      sec0_d = sec0_q + 4'd1;
    end
  end

  // Scheduler FSM: prescaler, elapsed time, alert seconds and missed count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      {min1_q, min0_q, sec1_q, sec0_q} <= '0;
      asec_q   <= '0;
      missed_q <= '0;
      alert_q  <= 1'b0;
      ilat1_q  <= '0;
      ilat0_q  <= '0;
    end else if (stop) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      {min1_q, min0_q, sec1_q, sec0_q} <= '0;
      asec_q   <= '0;
      alert_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          if (start_ok) begin
            ilat1_q <= int_min1;
            ilat0_q <= int_min0;
            state_q <= S_COUNTING;
          end
        end
        S_COUNTING: begin
          presc_q <= presc_next;
          if (tick) begin
            {min1_q, min0_q, sec1_q, sec0_q} <= {min1_d, min0_d, sec1_d, sec0_d};
            if (hit_interval) begin
              state_q <= S_ALERT;
              alert_q <= 1'b1;
              asec_q  <= '0;
            end
          end
        end
        S_ALERT: begin
          if (ack) begin
            state_q <= S_COUNTING;
            presc_q <= '0;
            {min1_q, min0_q, sec1_q, sec0_q} <= '0;
            asec_q  <= '0;
            alert_q <= 1'b0;
          end else if (snooze) begin
            state_q <= S_SNOOZE;
            presc_q <= '0;
            {min1_q, min0_q, sec1_q, sec0_q} <= '0;
            asec_q  <= '0;
            alert_q <= 1'b0;
          end else begin
            // Time stays frozen; the prescaler measures how long the alert is ignored
            presc_q <= presc_next;
            if (tick) begin
              if (asec_q == 6'd59) begin
                if (missed_q != 4'hF) missed_q <= missed_q + 4'd1;
                state_q <= S_COUNTING;
                {min1_q, min0_q, sec1_q, sec0_q} <= '0;
                asec_q  <= '0;
                alert_q <= 1'b0;
              end else begin
                asec_q <= asec_q + 6'd1;
              end
            end
          end
        end
        S_SNOOZE: begin
          if (ack) begin
            state_q <= S_COUNTING;
            presc_q <= '0;
            {min1_q, min0_q, sec1_q, sec0_q} <= '0;
          end else begin
            presc_q <= presc_next;
            if (tick) begin
              {min1_q, min0_q, sec1_q, sec0_q} <= {min1_d, min0_d, sec1_d, sec0_d};
              if (hit_snooze) begin
                state_q <= S_ALERT;
                alert_q <= 1'b1;
                asec_q  <= '0;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state  = state_q;
  assign alert  = alert_q;
  assign missed = missed_q;
  assign sec1   = sec1_q;
  assign sec0   = sec0_q;
  assign min1   = min1_q;
  assign min0   = min0_q;

endmodule
